seis_bits_decoder: RTL
======================

// Module: seis_bits_decoder
// PURPOSE
//  Receive end of the six-bit function interface. Takes the 6-bit word {iface2[2:0], iface1[2:0]}
//  and recovers the 3-bit function (a,b,c) and the destination-select bit d.
//  Requires the word to be stable (debounce), then presents one decoded result under a valid/ready handshake.
//  Sits between the output-interface pins/switch bank and the function-execution logic; counts malformed words.
// PARAMETERS
//  STABLE_CYCLES  4   consecutive identical sampled cycles required before decode (legal range >=1)
//  CNT_W          8   width of err_count (saturating)
// PORTS
//  clk        in   1      rising-edge clock, single clock domain
//  rst        in   1      synchronous, active-high reset
//  seis_bits  in   6      encoded word: [2:0] = interface-1 group, [5:3] = interface-2 group
//  in_valid   in   1      seis_bits is meaningful this cycle
//  out_valid  out  1      decoded result available
//  out_ready  in   1      consumer accepts result (transfer when out_valid & out_ready)
//  a,b,c      out  1 each recovered function bits
//  d          out  1      recovered select: 0 = interface 1, 1 = interface 2
//  ambig      out  1      word legal under both encodings (6'b110110); decoded as d=0
//  err        out  1      word matches neither encoding; a,b,c,d driven 0
//  err_count  out  CNT_W  number of err results transferred, saturates at all-ones
// BEHAVIOUR
//  Reset: state=IDLE; out_valid, a, b, c, d, ambig, err = 0; err_count = 0; stability counter = 0.
//   Reset mid-handshake drops out_valid on the next edge without a transfer.
//  Decode rules (on the stable word w):
//   pattern A (d=0): w[3]==0 & w[4]==1 & w[5]==1 -> a=w[0], b=w[1], c=w[2]
//   pattern B (d=1): w[0]==0 & w[1]==1 & w[2]==1 -> a=w[3], b=w[4], c=w[5]
//   A and B both: only w=6'b110110 -> A decode (a=0,b=1,c=1,d=0), ambig=1
//   neither: err=1, a=b=c=d=0
//  FSM:
//   IDLE   : on in_valid=1, capture seis_bits into ref register, cnt=1 -> SETTLE (or -> OUT if STABLE_CYCLES==1)
//   SETTLE : in_valid=0 -> IDLE; seis_bits!=ref -> recapture, cnt=1;
//            equal -> cnt+1; when cnt reaches STABLE_CYCLES -> OUT with decoded fields registered
//   OUT    : out_valid=1; outputs held constant regardless of input changes.
//            On out_valid&out_ready: -> HOLD, out_valid=0 next cycle; if err, err_count+1 (saturating)
//   HOLD   : wait for in_valid=0 or seis_bits!=ref -> IDLE (no re-emission of the same word)
//  Latency: word constant with in_valid high from edge t -> out_valid=1 after edge t+STABLE_CYCLES-1
//   (i.e. visible in the cycle after the STABLE_CYCLES-th sample).
//  out_valid never drops without a transfer (except reset); at most one result per stable word.
//  In SETTLE, a change on the same edge the count would complete aborts the decode (recapture wins).
//  err_count at max value stays at max; ambig and err never both 1.
// TESTING
//  1. rst, then w=6'b110001 (A: a=1,b=0,c=0), in_valid=1 held, ready=1 -> out_valid after STABLE_CYCLES
//     samples; a=1,b=0,c=0,d=0, ambig=0, err=0; single pulse only.
//  2. w=6'b101110 (B: a=1,b=0,c=1) -> d=1, a=1, b=0, c=1; then toggle to 6'b111110 -> second result a=b=c=1, d=1.
//  3. w=6'b110110 -> a=0,b=1,c=1,d=0, ambig=1.
//  4. w=6'b000000 x3 separate words, ready=1 -> err=1 each, err_count=3; with CNT_W=2 and 5 errors -> err_count=3.
//  5. Glitch: w flips at sample STABLE_CYCLES-1 -> no output until new word stable for full STABLE_CYCLES;
//     in_valid drop during SETTLE -> IDLE, no output.
//  6. out_ready=0 for 10 cycles while input changes -> out_valid and fields frozen;
//     rst asserted in OUT -> out_valid=0 next edge, err_count=0.

Source files
------------

// File: rtl/seis_bits_decoder.sv
// Six-bit function interface receiver: debounces the encoded word, decodes
// (a,b,c,d) and presents one result per stable word under valid/ready.
module seis_bits_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       seis_bits,
  input  logic             in_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             ambig,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_OUT    = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [5:0]       ref_q, ref_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_d;
  logic             a_d, b_d, c_d, d_d, ambig_d, err_d;
  logic [CNT_W-1:0] err_count_d;
  logic             load_dec;

  logic             pat_a, pat_b;
  logic             dec_a, dec_b, dec_c, dec_d, dec_ambig, dec_err;

  // Decode the current word; only latched once it has proven stable
  always_comb begin
    pat_a     = ~seis_bits[3] & seis_bits[4] & seis_bits[5];
    pat_b     = ~seis_bits[0] & seis_bits[1] & seis_bits[2];
    dec_a     = 1'b0;
    dec_b     = 1'b0;
    dec_c     = 1'b0;
    dec_d     = 1'b0;
    dec_ambig = pat_a & pat_b;
    dec_err   = ~pat_a & ~pat_b;
    if (pat_a) begin
      dec_a = seis_bits[0];
      dec_b = seis_bits[1];
      dec_c = seis_bits[2];
    end else if (pat_b) begin
      dec_a = seis_bits[3];
      dec_b = seis_bits[4];
      dec_c = seis_bits[5];
      dec_d = 1'b1;
    end
  end

  // Next-state, debounce counter, result capture and error counting
  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    cnt_d       = cnt_q;
    err_count_d = err_count;
    load_dec    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (in_valid) begin
          ref_d = seis_bits;
          cnt_d = CW'(1);
          if (STABLE_CYCLES <= 1) begin
            state_d  = S_OUT;
            load_dec = 1'b1;
          end else begin
            state_d = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (!in_valid) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (seis_bits != ref_q) begin
          // a change always restarts the count, even on the completing edge
          ref_d = seis_bits;
          cnt_d = CW'(1);
        end else if (cnt_q == CNT_LAST) begin
          state_d  = S_OUT;
          load_dec = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_HOLD;
          if (err && (err_count != '1)) begin
            err_count_d = err_count + CNT_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (!in_valid || (seis_bits != ref_q)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    a_d         = load_dec ? dec_a     : a;
    b_d         = load_dec ? dec_b     : b;
    c_d         = load_dec ? dec_c     : c;
    d_d         = load_dec ? dec_d     : d;
    ambig_d     = load_dec ? dec_ambig : ambig;
    err_d       = load_dec ? dec_err   : err;
    out_valid_d = (state_d == S_OUT);
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ref_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      a         <= 1'b0;
      b         <= 1'b0;
      c         <= 1'b0;
      d         <= 1'b0;
      ambig     <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      cnt_q     <= cnt_d;
      out_valid <= out_valid_d;
      a         <= a_d;
      b         <= b_d;
      c         <= c_d;
      d         <= d_d;
      ambig     <= ambig_d;
      err       <= err_d;
      err_count <= err_count_d;
    end
  end

endmodule
